// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter.
// Contents:
//   arb_state_e : FSM state encoding (IDLE=0, BUSY_I=1, BUSY_D=2).
//                 These values are also decoded by pipeline debug logic.
//   cnt_width   : width needed for a counter that saturates at a given maximum.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } arb_state_e;

  // Number of bits needed to hold the values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/mem_arb_fairness.sv
// Fetch-starvation guard for the memory port arbiter.
// It counts the data grants that overtake a pending fetch. Once MAX_WAIT such
// grants have happened, force_fetch is raised and the next tie goes to fetch.
// Ports:
//   clk, rst_n   : clock and synchronous active-low reset
//   data_grant   : a data access is granted this cycle
//   fetch_grant  : a fetch access is granted this cycle
//   if_req       : a fetch is pending
//   force_fetch  : the wait budget is used up, so fetch must win the next tie
module mem_arb_fairness #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic data_grant,
  input  logic fetch_grant,
  input  logic if_req,
  output logic force_fetch
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt_r;

  // Overtake counter: grows on data grants that bypass a pending fetch, saturates, cleared by a fetch grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end else if (fetch_grant) begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end else if (data_grant && if_req && (wait_cnt_r < MAX_CNT)) begin
      wait_cnt_r <= wait_cnt_r + CNT_W'(1);
    end
  end

  assign force_fetch = (wait_cnt_r >= MAX_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter that shares one single-port unified memory between the IF and MEM
// pipeline stages.
// Behaviour:
//   - Only one access is outstanding at a time.
//   - The memory-side fields are registered and held until mem_ready.
//   - Completion is routed back to the stage that owns the access.
//   - Data accesses win ties, unless mem_arb_fairness forces a pending fetch
//     through.
//   - if_kill drops the response of a fetch that is already in flight.
// Ports:
//   clk, rst_n                  : clock and synchronous active-low reset
//   if_req/if_addr/if_kill      : fetch request, PC, and squash pulse
//   if_ready/if_rdata           : fetch completion and instruction word
//   dm_req/dm_we/dm_addr/
//   dm_wdata/dm_wstrb           : data request fields
//   dm_ready/dm_rdata           : data completion and load data
//   mem_valid/mem_we/mem_addr/
//   mem_wdata/mem_wstrb         : registered memory request
//   mem_ready/mem_rdata         : memory completion and read data
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_kill,
  output logic                if_ready,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_wstrb,
  output logic                dm_ready,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                mem_valid,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = cnt_width(MAX_WAIT);

  arb_state_e state_r;
  arb_state_e state_s;
  logic       grant_d_s;
  logic       grant_i_s;
  logic       force_fetch_s;
  logic       kill_pend_r;

  mem_arb_fairness #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_fair (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_grant  (grant_d_s),
    .fetch_grant (grant_i_s),
    .if_req      (if_req),
    .force_fetch (force_fetch_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state, grant decision, and completion strobes.
  // Completions are combinational from the state and mem_ready, and are forced
  // low while reset is asserted.
  always_comb begin
    state_s   = state_r;
    grant_d_s = 1'b0;
    grant_i_s = 1'b0;
    if_ready  = 1'b0;
    dm_ready  = 1'b0;
    if (!rst_n) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (dm_req && (!if_req || !force_fetch_s)) begin
            grant_d_s = 1'b1;
            state_s   = ST_BUSY_D;
          end else if (if_req) begin
            grant_i_s = 1'b1;
            state_s   = ST_BUSY_I;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_BUSY_I: begin
          if (mem_ready) begin
            // A kill that arrives earlier or in the same cycle suppresses the response.
            if_ready = !kill_pend_r && !if_kill;
            state_s  = ST_IDLE;
          end else begin
            state_s = ST_BUSY_I;
          end
        end
        ST_BUSY_D: begin
          if (mem_ready) begin
            dm_ready = 1'b1;
            state_s  = ST_IDLE;
          end else begin
            state_s = ST_BUSY_D;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // Memory request registers.
  // They are loaded on a grant and held until the memory completes.
  // mem_valid falls after completion, so the next grant needs at least one
  // IDLE cycle and no access is issued back to back.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= {ADDR_W{1'b0}};
      mem_wdata <= {DATA_W{1'b0}};
      mem_wstrb <= {STRB_W{1'b0}};
    end else if (grant_d_s) begin
      mem_valid <= 1'b1;
      mem_we    <= dm_we;
      mem_addr  <= dm_addr;
      mem_wdata <= dm_wdata;
      mem_wstrb <= dm_we ? dm_wstrb : {STRB_W{1'b0}};
    end else if (grant_i_s) begin
      mem_valid <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= if_addr;
      mem_wdata <= {DATA_W{1'b0}};
      mem_wstrb <= {STRB_W{1'b0}};
    end else if (mem_valid && mem_ready) begin
      mem_valid <= 1'b0;
    end
  end

  // Pending-kill flag for the fetch in flight.
  // It is only meaningful while in BUSY_I and clears when that state is left.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kill_pend_r <= 1'b0;
    end else if (state_r == ST_BUSY_I) begin
      if (mem_ready) begin
        kill_pend_r <= 1'b0;
      end else if (if_kill) begin
        kill_pend_r <= 1'b1;
      end
    end else begin
      kill_pend_r <= 1'b0;
    end
  end

  assign if_rdata = mem_rdata;
  assign dm_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_kill, if_ready;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_ready;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_wstrb;
  logic        mem_valid, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int   checks = 0;
  int   errors = 0;
  txn_t exp_q[$];
  logic mon_prev = 1'b0;

  // Memory model: the read data is a fixed scramble of the address.
  localparam logic [31:0] SCRAMBLE = 32'hA5A5_0000;
  assign mem_rdata = mem_addr ^ SCRAMBLE;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_ready(if_ready), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_wstrb(dm_wstrb), .dm_ready(dm_ready), .dm_rdata(dm_rdata),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  task automatic check_eq(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic txn_t mk(input logic we, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] s);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = d; t.wstrb = s;
    return t;
  endfunction

  // Grant monitor: every new memory access is compared in order against the scoreboard.
  initial begin
    txn_t e;
    forever begin
      @(posedge clk);
      #2;
      if (mem_valid === 1'b1 && !mon_prev) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_grant", 72'd1, 72'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("grant_fields", {3'b000, mem_we, mem_addr, mem_wdata, mem_wstrb}, {3'b000, e});
        end
      end
      mon_prev = (mem_valid === 1'b1);
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int dcount;
    int icount;
    rst_n = 1'b0; if_req = 1'b1; dm_req = 1'b1; if_kill = 1'b0;
    if_addr = 32'h0; dm_we = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0; dm_wstrb = 4'h0;
    mem_ready = 1'b1;

    // Reset is held for two cycles with both requests high.
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq("rst_mem_valid", 72'(mem_valid), 72'd0);
      check_eq("rst_if_ready", 72'(if_ready), 72'd0);
      check_eq("rst_dm_ready", 72'(dm_ready), 72'd0);
    end
    if_req = 1'b0; dm_req = 1'b0; rst_n = 1'b1;
    step();
    check_eq("rst_state_idle", 72'(dut.state_r), 72'(ST_IDLE));
    check_eq("rst_mem_valid_after", 72'(mem_valid), 72'd0);

    // A lone fetch with the memory always ready.
    if_req = 1'b1; if_addr = 32'h100;
    exp_q.push_back(mk(1'b0, 32'h100, 32'h0, 4'h0));
    step();
    check_eq("fetch_valid", 72'(mem_valid), 72'd1);
    check_eq("fetch_addr", 72'(mem_addr), 72'h100);
    check_eq("fetch_wstrb", 72'(mem_wstrb), 72'h0);
    check_eq("fetch_ready", 72'(if_ready), 72'd1);
    check_eq("fetch_rdata", 72'(if_rdata), 72'(32'h100 ^ SCRAMBLE));
    if_req = 1'b0;
    step();
    check_eq("fetch_no_reissue", 72'(mem_valid), 72'd0);

    // Tie: the data store goes first, and its fields stay stable while the memory stalls.
    mem_ready = 1'b0;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2000; dm_wdata = 32'hDEADBEEF; dm_wstrb = 4'hF;
    if_req = 1'b1; if_addr = 32'h300;
    exp_q.push_back(mk(1'b1, 32'h2000, 32'hDEADBEEF, 4'hF));
    exp_q.push_back(mk(1'b0, 32'h300, 32'h0, 4'h0));
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("tie_stall_fields", {3'b000, mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb},
               {3'b000, 1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 4'hF});
      check_eq("tie_stall_dm_ready", 72'(dm_ready), 72'd0);
    end
    mem_ready = 1'b1;
    #1;
    check_eq("tie_dm_ready", 72'(dm_ready), 72'd1);
    check_eq("tie_if_ready_low", 72'(if_ready), 72'd0);
    dm_req = 1'b0;
    step();
    check_eq("tie_idle", 72'(dut.state_r), 72'(ST_IDLE));
    step();
    check_eq("tie_fetch_ready", 72'(if_ready), 72'd1);
    check_eq("tie_fetch_rdata", 72'(if_rdata), 72'(32'h300 ^ SCRAMBLE));
    if_req = 1'b0;
    step();

    // Starvation: both requests are held; expect four loads, then the fetch, then data again.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h3000; dm_wdata = 32'h0; dm_wstrb = 4'hF;
    if_req = 1'b1; if_addr = 32'h400;
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(1'b0, 32'h3000, 32'h0, 4'h0));
    exp_q.push_back(mk(1'b0, 32'h400, 32'h0, 4'h0));
    exp_q.push_back(mk(1'b0, 32'h3000, 32'h0, 4'h0));
    dcount = 0; icount = 0;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 9) begin
        check_eq("starve_fetch_state", 72'(dut.state_r), 72'(ST_BUSY_I));
      end else begin
        check_eq("starve_mem_valid", 72'(mem_valid), 72'(c % 2));
      end
      if (if_ready) begin
        icount++;
        check_eq("starve_if_rdata", 72'(if_rdata), 72'(32'h400 ^ SCRAMBLE));
        if_req = 1'b0;
      end
      if (dm_ready) begin
        dcount++;
        if (!if_req) dm_req = 1'b0;
      end
    end
    check_eq("starve_data_count", 72'(dcount), 72'd5);
    check_eq("starve_fetch_count", 72'(icount), 72'd1);

    // Kill while in flight: the killed fetch never completes, and the new PC is fetched next.
    mem_ready = 1'b0; if_req = 1'b1; if_addr = 32'h180;
    exp_q.push_back(mk(1'b0, 32'h180, 32'h0, 4'h0));
    exp_q.push_back(mk(1'b0, 32'h200, 32'h0, 4'h0));
    step();
    if_kill = 1'b1; if_addr = 32'h200;
    step();
    if_kill = 1'b0;
    check_eq("kill_if_ready_c2", 72'(if_ready), 72'd0);
    step();
    mem_ready = 1'b1;
    #1;
    check_eq("kill_if_ready_at_mem_ready", 72'(if_ready), 72'd0);
    step();
    check_eq("kill_state_idle", 72'(dut.state_r), 72'(ST_IDLE));
    check_eq("kill_if_ready_idle", 72'(if_ready), 72'd0);
    step();
    check_eq("kill_new_fetch_ready", 72'(if_ready), 72'd1);
    check_eq("kill_new_fetch_rdata", 72'(if_rdata), 72'(32'h200 ^ SCRAMBLE));
    if_req = 1'b0;
    step();

    // Kill in the same cycle as mem_ready.
    mem_ready = 1'b0; if_req = 1'b1; if_addr = 32'h240;
    exp_q.push_back(mk(1'b0, 32'h240, 32'h0, 4'h0));
    exp_q.push_back(mk(1'b0, 32'h280, 32'h0, 4'h0));
    step();
    mem_ready = 1'b1; if_kill = 1'b1; if_addr = 32'h280;
    #1;
    check_eq("kill_coincident_if_ready", 72'(if_ready), 72'd0);
    step();
    if_kill = 1'b0;
    check_eq("kill_coincident_idle", 72'(dut.state_r), 72'(ST_IDLE));
    step();
    check_eq("kill_coincident_next_ready", 72'(if_ready), 72'd1);
    if_req = 1'b0;
    step();

    // Reset in the middle of a stalled store.
    mem_ready = 1'b0;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2400; dm_wdata = 32'h12345678; dm_wstrb = 4'h3;
    exp_q.push_back(mk(1'b1, 32'h2400, 32'h12345678, 4'h3));
    step();
    step();
    check_eq("midrst_busy_d", 72'(dut.state_r), 72'(ST_BUSY_D));
    rst_n = 1'b0; mem_ready = 1'b1;
    #1;
    check_eq("midrst_dm_ready_comb", 72'(dm_ready), 72'd0);
    step();
    check_eq("midrst_mem_valid", 72'(mem_valid), 72'd0);
    check_eq("midrst_dm_ready", 72'(dm_ready), 72'd0);
    dm_req = 1'b0; rst_n = 1'b1;
    step();
    check_eq("midrst_idle", 72'(dut.state_r), 72'(ST_IDLE));
    check_eq("midrst_dm_ready_after", 72'(dm_ready), 72'd0);

    step();
    step();
    check_eq("scoreboard_empty", 72'(exp_q.size()), 72'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
